// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 3-sample majority vote per bit, optional parity, 1-2 stop bits,
// break detection and a valid/ready hold register with overrun signalling.
//
// state      | meaning
// IDLE       | waiting for a 1->0 edge on the line
// START      | validating the start bit; a majority of 1 is a false start
// DATA       | shifting in DATA_BITS bits, LSB first
// PARITY     | sampling the parity bit (only when PARITY_EN)
// STOP       | checking STOP_BITS stop bits; frame completes at the last decision point
// BREAK_WAIT | all-zero frame seen; waiting for the line to return high
module uart_rx_ovs #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 rx_sync_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun,
    output logic                 break_detect
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = 4;
    localparam logic [TICK_W-1:0] T_S0  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] T_S1  = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] T_DEC = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TICK_W-1:0] T_END = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_cnt, div_lat;
    logic [TICK_W-1:0]    tick_idx;
    logic [BIT_W-1:0]     bit_idx;
    logic                 prev_q, s0_q, s1_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_acc, ferr_acc, zero_acc;

    logic tick, decide, bit_end, vote, in_frame;
    logic start_det, clr_bit, complete, brk, ferr_fin, perr_fin;

    assign tick     = (div_cnt == div_lat);
    assign decide   = tick && (tick_idx == T_DEC);
    assign bit_end  = tick && (tick_idx == T_END);
    assign vote     = (s0_q & s1_q) | (s0_q & rx_sync_in) | (s1_q & rx_sync_in);
    assign in_frame = (state_q == START) || (state_q == DATA) ||
                      (state_q == PARITY) || (state_q == STOP);
    assign brk      = zero_acc && !vote;
    assign ferr_fin = ferr_acc || !vote;
    assign perr_fin = PARITY_EN && (par_acc != PARITY_ODD);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_det = 1'b0;
        clr_bit   = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                if (prev_q && !rx_sync_in) begin
                    state_d   = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (decide && vote) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                    clr_bit = 1'b1;
                end
            end
            DATA: begin
                if (bit_end && bit_idx == LAST_DATA) begin
                    clr_bit = 1'b1;
                    state_d = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    clr_bit = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                // Completing at the decision point leaves time to catch a back-to-back start edge.
                if (decide && bit_idx == LAST_STOP) begin
                    complete = 1'b1;
                    state_d  = brk ? BREAK_WAIT : IDLE;
                end
            end
            BREAK_WAIT: begin
                if (rx_sync_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // baud_div is only picked up at a wrap so a mid-count change cannot skip the compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            div_lat <= baud_div;
        end else if (start_det || tick) begin
            div_cnt <= '0;
            div_lat <= baud_div;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_idx <= '0;
            bit_idx  <= '0;
            prev_q   <= 1'b1;
            s0_q     <= 1'b1;
            s1_q     <= 1'b1;
        end else begin
            prev_q <= rx_sync_in;
            if (start_det) begin
                tick_idx <= '0;
            end else if (tick && in_frame) begin
                tick_idx <= (tick_idx == T_END) ? '0 : tick_idx + TICK_W'(1);
            end
            if (clr_bit) begin
                bit_idx <= '0;
            end else if (bit_end && (state_q == DATA || state_q == STOP)) begin
                bit_idx <= bit_idx + BIT_W'(1);
            end
            if (tick && tick_idx == T_S0) s0_q <= rx_sync_in;
            if (tick && tick_idx == T_S1) s1_q <= rx_sync_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            par_acc  <= 1'b0;
            ferr_acc <= 1'b0;
            zero_acc <= 1'b1;
        end else if (start_det) begin
            par_acc  <= 1'b0;
            ferr_acc <= 1'b0;
            zero_acc <= 1'b1;
        end else if (decide) begin
            if (state_q == DATA) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
            if (state_q == DATA || state_q == PARITY) par_acc <= par_acc ^ vote;
            if (state_q == STOP && !vote) ferr_acc <= 1'b1;
            if ((state_q == DATA || state_q == PARITY || state_q == STOP) && vote) zero_acc <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data      <= '0;
            valid        <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            overrun      <= 1'b0;
            break_detect <= 1'b0;
        end else begin
            overrun      <= 1'b0;
            break_detect <= 1'b0;
            if (valid && ready) valid <= 1'b0;
            if (complete) begin
                if (brk) begin
                    break_detect <= 1'b1;
                end else if (valid && !ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data      <= shift_q;
                    frame_error  <= ferr_fin;
                    parity_error <= perr_fin;
                    valid        <= 1'b1;
                end
            end
        end
    end
endmodule
